// File: rtl/iob_pulse_sched.sv
// Round-robin scheduler sharing one start-delay/pulse-duration timer among N_REQ requesters.
// Each grant waits start_w cycles, pulses the winner's line for dur_w cycles, then strobes done.
module iob_pulse_sched #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic [CNT_W-1:0] cfg_start_i,
    input  logic [CNT_W-1:0] cfg_dur_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             abort_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] pulse_out_o,
    output logic [N_REQ-1:0] done_o,
    output logic             busy_o
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, DONE} state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [CNT_W-1:0]   start_r_q, dur_r_q, start_w_q, dur_w_q;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx, ptr_d;
    logic [PTR_W:0]     sum;

    // Walk offsets high-to-low so the smallest offset from ptr_q wins last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        sum     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ))
                sum = sum - (PTR_W+1)'(N_REQ);
            if (req_i[sum[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = sum[PTR_W-1:0];
            end
        end
        ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            start_r_q <= CNT_W'(5);
            dur_r_q   <= CNT_W'(5);
            start_w_q <= CNT_W'(5);
            dur_w_q   <= CNT_W'(5);
        end else begin
            if (cfg_we_i) begin
                start_r_q <= cfg_start_i;
                dur_r_q   <= cfg_dur_i;
            end
            if (abort_i && state_q != IDLE) begin
                state_q <= IDLE;
                gnt_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (win_vld) begin
                        // Working copies take the pre-write config values on a simultaneous cfg_we.
                        gnt_q     <= N_REQ'(1) << win_idx;
                        ptr_q     <= ptr_d;
                        cnt_q     <= '0;
                        start_w_q <= start_r_q;
                        dur_w_q   <= dur_r_q;
                        if (start_r_q != '0)    state_q <= DELAY;
                        else if (dur_r_q != '0) state_q <= PULSE;
                        else                    state_q <= DONE;
                    end
                    DELAY: begin
                        if (cnt_q == start_w_q - CNT_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= (dur_w_q == '0) ? DONE : PULSE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PULSE: begin
                        if (cnt_q == dur_w_q - CNT_W'(1)) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign pulse_out_o = gnt_q & {N_REQ{state_q == PULSE}};
    assign done_o      = gnt_q & {N_REQ{state_q == DONE}};
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_iob_pulse_sched.sv
// Scoreboard bench: each expected operation is queued when its request is driven and
// checked cycle by cycle once the scheduler grants it.
module tb_iob_pulse_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cfg_we_i = 1'b0;
    logic [W-1:0] cfg_start_i = '0;
    logic [W-1:0] cfg_dur_i = '0;
    logic [N-1:0] req_i = '0;
    logic         abort_i = 1'b0;
    logic [N-1:0] gnt_o, pulse_out_o, done_o;
    logic         busy_o;

    iob_pulse_sched #(.N_REQ(N), .CNT_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_start_i(cfg_start_i),
        .cfg_dur_i(cfg_dur_i), .req_i(req_i), .abort_i(abort_i), .gnt_o(gnt_o),
        .pulse_out_o(pulse_out_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // ab: cycle in which abort/reset is driven (-1 none); gap: idle cycles before grant (-1 any)
    typedef struct { int idx; int s; int d; int ab; int gap; } exp_t;
    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0, n_err = 0;
    bit   in_op = 1'b0;
    int   cyc = 0, idle_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int s, input int d, input int ab, input int gap);
        exp_t e;
        e.idx = idx; e.s = s; e.d = d; e.ab = ab; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic check_cycle();
        logic [N-1:0] oh;
        oh = N'(1) << cur.idx;
        if (cur.ab >= 0 && cyc == cur.ab + 1) begin
            chk("kill_gnt", 32'(gnt_o), 0);
            chk("kill_busy", 32'(busy_o), 0);
            chk("kill_pulse", 32'(pulse_out_o), 0);
            chk("kill_done", 32'(done_o), 0);
            in_op = 1'b0;
        end else begin
            chk("gnt", 32'(gnt_o), 32'(oh));
            chk("busy", 32'(busy_o), 1);
            chk("pulse", 32'(pulse_out_o), (cyc >= cur.s && cyc < cur.s + cur.d) ? 32'(oh) : 0);
            chk("done", 32'(done_o), (cyc == cur.s + cur.d) ? 32'(oh) : 0);
            if (cyc == cur.s + cur.d) in_op = 1'b0;
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        if (in_op) begin
            cyc++;
            check_cycle();
        end else if (busy_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", 32'(gnt_o), 0);
            end else begin
                cur = sb.pop_front();
                if (cur.gap >= 0) chk("idle_gap", 32'(idle_cnt), 32'(cur.gap));
                idle_cnt = 0;
                cyc = 0;
                in_op = 1'b1;
                check_cycle();
            end
        end else begin
            idle_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
    endtask

    task automatic cfg(input int s, input int d);
        cfg_we_i = 1'b1; cfg_start_i = W'(s); cfg_dur_i = W'(d);
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_op || busy_o) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("timeout", 1, 0);
    endtask

    task automatic one_op(input logic [N-1:0] r, input int idx, input int s, input int d);
        push(idx, s, d, -1, -1);
        req_i = r;
        tick();
        req_i = '0;
        wait_idle();
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_pulse", 32'(pulse_out_o), 0);
        chk("rst_done", 32'(done_o), 0);

        // default 5/5 config, request dropped right after grant
        one_op(4'b0001, 0, 5, 5);
        chk("post_op_gnt", 32'(gnt_o), 0);

        // round-robin fairness, one grant every S+D+2 = 4 cycles
        do_reset();
        cfg(1, 1);
        push(0, 1, 1, -1, -1);
        push(1, 1, 1, -1, 1);
        push(2, 1, 1, -1, 1);
        push(3, 1, 1, -1, 1);
        push(0, 1, 1, -1, 1);
        req_i = 4'b1111;
        repeat (17) @(posedge clk_i);
        #1 req_i = '0;
        wait_idle();

        // zero-length fields
        cfg(0, 3); one_op(4'b0001, 0, 0, 3);
        cfg(2, 0); one_op(4'b0001, 0, 2, 0);
        cfg(0, 0); one_op(4'b0001, 0, 0, 0);

        // cfg write on the grant edge: current op keeps 5/5, next uses 2/2
        do_reset();
        push(0, 5, 5, -1, -1);
        push(0, 2, 2, -1, 1);
        req_i = 4'b0001;
        cfg_we_i = 1'b1; cfg_start_i = 2; cfg_dur_i = 2;
        tick();
        cfg_we_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1 req_i = '0;
        wait_idle();

        // abort in cycle 6, then abort-in-IDLE still arbitrates from advanced ptr
        do_reset();
        push(2, 5, 5, 6, -1);
        req_i = 4'b0100;
        tick();
        req_i = '0;
        repeat (6) tick();
        abort_i = 1'b1;
        tick();
        push(3, 5, 5, -1, -1);
        req_i = 4'b1111;
        tick();
        abort_i = 1'b0;
        req_i = '0;
        wait_idle();

        // reset mid-pulse with a simultaneous cfg write that must be discarded
        push(1, 5, 5, 7, -1);
        req_i = 4'b0010;
        tick();
        req_i = '0;
        repeat (7) tick();
        rst_i = 1'b1;
        cfg_we_i = 1'b1; cfg_start_i = 1; cfg_dur_i = 1;
        tick();
        rst_i = 1'b0;
        cfg_we_i = 1'b0;
        push(0, 5, 5, -1, -1);
        req_i = 4'b1111;
        tick();
        req_i = '0;
        wait_idle();
        if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
